// File: rtl/max7219_frame_sequencer.sv
// rtl/max7219_frame_sequencer.sv - MAX7219 init broadcast and periodic row refresh sequencer
module max7219_frame_sequencer #(
  parameter int         DISP_ROWS    = 1,
  parameter int         DISP_COLUMNS = 1,
  parameter int         CLK_FREQ_HZ  = 100_000_000,
  parameter int         REFRESH_HZ   = 10,
  parameter logic [3:0] INTENSITY    = 4'h8
) (
  input  logic                                              i_Clk,
  input  logic                                              i_Rst,
  input  logic                                              i_Enable,
  input  logic [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0] i_DataStream,
  output logic [15:0]                                       o_Word,
  output logic                                              o_Word_Valid,
  input  logic                                              i_Word_Ready,
  input  logic                                              i_Shifter_Idle,
  output logic                                              o_Load,
  output logic                                              o_Frame_Done,
  output logic                                              o_Busy
);

  localparam int N     = DISP_ROWS * DISP_COLUMNS;
  localparam int P     = CLK_FREQ_HZ / REFRESH_HZ;
  localparam int DEV_W = $clog2(N) + 1;
  localparam int TMR_W = $clog2(P);

  localparam logic [DEV_W-1:0] DEV_LAST    = DEV_W'(N - 1);
  localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(P - 1);
  localparam logic [2:0]       CMD_LAST    = 3'd4;
  localparam logic [2:0]       STREAM_LAST = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT_WORD,
    ST_INIT_LOAD,
    ST_WAIT,
    ST_ROW_WORD,
    ST_ROW_LOAD
  } state_t;

  state_t r_State;
  state_t w_State_Next;

  logic [DEV_W-1:0] r_Dev;
  logic [DEV_W-1:0] w_Dev_Next;
  logic [2:0]       r_Stream;
  logic [2:0]       w_Stream_Next;
  logic [2:0]       r_Cmd;
  logic [2:0]       w_Cmd_Next;
  logic             r_Frame_Done;
  logic             w_Frame_Done_Next;
  logic             w_Capture;

  logic [TMR_W-1:0] r_Timer;
  logic             r_Pending;
  logic             w_Tick;

  logic [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0] r_Snapshot;
  logic [N*16-1:0] w_RowFlat;
  logic [15:0]     w_RowWord;
  logic [15:0]     w_InitWord;

  // Init command table: {4'h0, register address, data}
  function automatic logic [15:0] f_InitWord(input logic [2:0] i_Idx);
    case (i_Idx)
      3'd0:    f_InitWord = {4'h0, 4'hF, 8'h00};
      3'd1:    f_InitWord = {4'h0, 4'hB, 8'h07};
      3'd2:    f_InitWord = {4'h0, 4'h9, 8'h00};
      3'd3:    f_InitWord = {4'h0, 4'hA, 4'h0, INTENSITY};
      3'd4:    f_InitWord = {4'h0, 4'hC, 8'h01};
      default: f_InitWord = 16'h0000;
    endcase
  endfunction

  // Device d = r*DISP_COLUMNS + c sits at flat word offset d inside one stream
  assign w_RowFlat    = r_Snapshot[r_Stream];
  assign w_RowWord    = w_RowFlat[int'(r_Dev)*16 +: 16];
  assign w_InitWord   = f_InitWord(r_Cmd);
  assign w_Tick       = (r_State != ST_IDLE) && (r_Timer == TMR_LAST);
  assign o_Busy       = (r_State != ST_IDLE);
  assign o_Frame_Done = r_Frame_Done;

  // Next-state, counter and output decode
  always_comb begin
    w_State_Next      = r_State;
    w_Dev_Next        = r_Dev;
    w_Stream_Next     = r_Stream;
    w_Cmd_Next        = r_Cmd;
    w_Frame_Done_Next = 1'b0;
    w_Capture         = 1'b0;
    o_Word            = 16'h0000;
    o_Word_Valid      = 1'b0;
    o_Load            = 1'b0;

    case (r_State)
      ST_IDLE: begin
        w_Dev_Next    = '0;
        w_Stream_Next = '0;
        w_Cmd_Next    = '0;
        if (i_Enable) begin
          w_State_Next = ST_INIT_WORD;
          w_Dev_Next   = DEV_LAST;
        end
      end

      ST_INIT_WORD: begin
        o_Word       = w_InitWord;
        o_Word_Valid = 1'b1;
        if (i_Word_Ready) begin
          if (r_Dev == '0) begin
            w_State_Next = ST_INIT_LOAD;
          end else begin
            w_Dev_Next = r_Dev - 1'b1;
          end
        end
      end

      ST_INIT_LOAD: begin
        // Latch only once the shifter has drained every accepted bit
        if (i_Shifter_Idle) begin
          o_Load     = 1'b1;
          w_Dev_Next = DEV_LAST;
          if (r_Cmd == CMD_LAST) begin
            // First frame follows init directly, without waiting for a tick
            w_State_Next  = ST_ROW_WORD;
            w_Cmd_Next    = '0;
            w_Stream_Next = '0;
            w_Capture     = 1'b1;
          end else begin
            w_State_Next = ST_INIT_WORD;
            w_Cmd_Next   = r_Cmd + 1'b1;
          end
        end
      end

      ST_WAIT: begin
        if (!i_Enable) begin
          w_State_Next = ST_IDLE;
        end else if (r_Pending || w_Tick) begin
          w_State_Next  = ST_ROW_WORD;
          w_Dev_Next    = DEV_LAST;
          w_Stream_Next = '0;
          w_Capture     = 1'b1;
        end
      end

      ST_ROW_WORD: begin
        o_Word       = w_RowWord;
        o_Word_Valid = 1'b1;
        if (i_Word_Ready) begin
          if (r_Dev == '0) begin
            w_State_Next = ST_ROW_LOAD;
          end else begin
            w_Dev_Next = r_Dev - 1'b1;
          end
        end
      end

      ST_ROW_LOAD: begin
        if (i_Shifter_Idle) begin
          o_Load     = 1'b1;
          w_Dev_Next = DEV_LAST;
          if (r_Stream == STREAM_LAST) begin
            w_State_Next      = ST_WAIT;
            w_Stream_Next     = '0;
            w_Frame_Done_Next = 1'b1;
          end else begin
            w_State_Next  = ST_ROW_WORD;
            w_Stream_Next = r_Stream + 1'b1;
          end
        end
      end

      default: begin
        w_State_Next = ST_IDLE;
      end
    endcase
  end

  // State, counter and frame-done registers
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State      <= ST_IDLE;
      r_Dev        <= '0;
      r_Stream     <= '0;
      r_Cmd        <= '0;
      r_Frame_Done <= 1'b0;
    end else begin
      r_State      <= w_State_Next;
      r_Dev        <= w_Dev_Next;
      r_Stream     <= w_Stream_Next;
      r_Cmd        <= w_Cmd_Next;
      r_Frame_Done <= w_Frame_Done_Next;
    end
  end

  // Free-running refresh timer; ticks outside WAIT collapse into one pending flag
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Timer   <= '0;
      r_Pending <= 1'b0;
    end else if (r_State == ST_IDLE) begin
      r_Timer   <= '0;
      r_Pending <= 1'b0;
    end else begin
      r_Timer <= (r_Timer == TMR_LAST) ? '0 : r_Timer + 1'b1;
      if (r_State == ST_WAIT) begin
        r_Pending <= 1'b0;
      end else if (w_Tick) begin
        r_Pending <= 1'b1;
      end
    end
  end

  // Frame snapshot so that stream changes mid-frame only show up next frame
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Snapshot <= '0;
    end else if (w_Capture) begin
      r_Snapshot <= i_DataStream;
    end
  end

endmodule

// File: tb/tb_max7219_frame_sequencer.sv
// tb/tb_max7219_frame_sequencer.sv - scoreboard bench for max7219_frame_sequencer
module tb_max7219_frame_sequencer;

  localparam int R = 1;
  localparam int C = 2;
  localparam int N = R * C;
  localparam int P = 100;

  typedef logic [0:7][R-1:0][C-1:0][15:0] ds_t;

  localparam logic [1:0] EV_WORD = 2'd0;
  localparam logic [1:0] EV_LOAD = 2'd1;
  localparam logic [1:0] EV_DONE = 2'd2;

  logic        clk;
  logic        rst;
  logic        en;
  logic        ready;
  logic        sidle;
  ds_t         data;
  logic [15:0] o_word;
  logic        o_valid;
  logic        o_load;
  logic        o_done;
  logic        o_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frames_done = 0;
  int mid_seq = 0;
  int load_cnt = 0;
  int idle_cnt = 0;
  logic bp = 1'b0;
  logic acc_flag = 1'b0;
  logic hold_valid = 1'b0;
  logic [15:0] hold_word = 16'h0;
  logic [17:0] exp_q[$];
  int done_cyc[$];

  max7219_frame_sequencer #(
    .DISP_ROWS(R),
    .DISP_COLUMNS(C),
    .CLK_FREQ_HZ(1000),
    .REFRESH_HZ(10),
    .INTENSITY(4'h8)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .i_Enable(en),
    .i_DataStream(data),
    .o_Word(o_word),
    .o_Word_Valid(o_valid),
    .i_Word_Ready(ready),
    .i_Shifter_Idle(sidle),
    .o_Load(o_load),
    .o_Frame_Done(o_done),
    .o_Busy(o_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [1:0] k, input logic [15:0] w, input string nm);
    logic [17:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected kind=%0d word=%h with empty queue", nm, k, w);
    end else begin
      e = exp_q.pop_front();
      if (e !== {k, w}) begin
        errors++;
        $display("FAIL %s: got kind=%0d word=%h expected kind=%0d word=%h", nm, k, w, e[17:16], e[15:0]);
      end
    end
  endtask

  task automatic finish_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out", nm);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic push_init();
    logic [15:0] cmds [5];
    cmds = '{16'h0F00, 16'h0B07, 16'h0900, 16'h0A08, 16'h0C01};
    for (int i = 0; i < 5; i++) begin
      for (int d = 0; d < N; d++) exp_q.push_back({EV_WORD, cmds[i]});
      exp_q.push_back({EV_LOAD, 16'h0});
    end
  endtask

  task automatic push_frame(input ds_t v);
    for (int s = 0; s < 8; s++) begin
      for (int d = N - 1; d >= 0; d--) exp_q.push_back({EV_WORD, v[s][d / C][d % C]});
      exp_q.push_back({EV_LOAD, 16'h0});
    end
    exp_q.push_back({EV_DONE, 16'h0});
  endtask

  task automatic rand_data(output ds_t v);
    for (int s = 0; s < 8; s++)
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++)
          v[s][r][c] = 16'($urandom);
  endtask

  task automatic wait_mid();
    int m0;
    logic seen;
    m0 = mid_seq;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (mid_seq != m0) seen = 1'b1;
    end
    if (!seen) finish_now("mid_frame_wait");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy_low(input string nm);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (!o_busy) seen = 1'b1;
    end
    if (!seen) finish_now(nm);
  endtask

  // Shifter model: random acceptance and a 5-cycle drain after every accepted word
  initial begin
    ready = 1'b1;
    sidle = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp) begin
        ready = ($urandom_range(0, 9) < 3);
        if (acc_flag) idle_cnt = 5;
        sidle = (idle_cnt == 0);
        if (idle_cnt > 0) idle_cnt--;
      end else begin
        ready = 1'b1;
        sidle = 1'b1;
        idle_cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted word, LOAD and frame-done
  initial forever begin
    @(negedge clk);
    if (rst) begin
      acc_flag = 1'b0;
      hold_valid = 1'b0;
      load_cnt = 0;
    end else begin
      if (!o_busy) load_cnt = 0;
      if (hold_valid && o_valid) chk("word_held", {16'h0, o_word}, {16'h0, hold_word});
      acc_flag = o_valid && ready;
      hold_valid = o_valid && !ready;
      hold_word = o_word;
      if (acc_flag) expect_ev(EV_WORD, o_word, "word");
      if (o_load) begin
        chk("load_when_idle", {31'h0, sidle}, 32'h1);
        expect_ev(EV_LOAD, 16'h0, "load");
        load_cnt++;
        if (load_cnt > 5 && (load_cnt - 5) % 8 == 3) mid_seq++;
      end
      if (o_done) begin
        expect_ev(EV_DONE, 16'h0, "frame_done");
        done_cyc.push_back(cyc);
        frames_done++;
      end
    end
  end

  initial begin
    ds_t d;
    int en_cyc;
    int f0;
    logic seen;

    rst = 1'b1;
    en = 1'b0;
    data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_word", {16'h0, o_word}, 32'h0);
    chk("rst_valid", {31'h0, o_valid}, 32'h0);
    chk("rst_load", {31'h0, o_load}, 32'h0);
    chk("rst_done", {31'h0, o_done}, 32'h0);
    chk("rst_busy", {31'h0, o_busy}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_busy", {31'h0, o_busy}, 32'h0);

    for (int s = 0; s < 8; s++)
      for (int c = 0; c < C; c++)
        d[s][0][c] = 16'(16'h0100 * (s + 1) + c);
    data = d;
    push_init();
    push_frame(d);
    en = 1'b1;
    en_cyc = cyc;
    @(posedge clk);
    #1;
    chk("enable_busy", {31'h0, o_busy}, 32'h1);
    chk("enable_valid", {31'h0, o_valid}, 32'h1);
    chk("enable_first_word", {16'h0, o_word}, 32'h0F00);

    for (int f = 1; f <= 10; f++) begin
      wait_mid();
      if (f == 5) begin
        bp = 1'b1;
        chk("zero_wait_frames", done_cyc.size() >= 4, 32'h1);
        if (done_cyc.size() >= 4) begin
          chk("first_frame_done_cycle", done_cyc[0], en_cyc + 1 + 13 * (N + 1));
          for (int i = 1; i < 4; i++)
            chk("refresh_done_cycle", done_cyc[i], en_cyc + 1 + P * i + 8 * (N + 1));
        end
      end
      if (f == 10) begin
        en = 1'b0;
      end else begin
        if (f % 2 == 0) rand_data(d);
        data = d;
        push_frame(d);
      end
    end

    wait_busy_low("disable_to_idle");
    chk("disable_busy", {31'h0, o_busy}, 32'h0);
    chk("disable_queue_empty", exp_q.size(), 32'h0);
    repeat (150) @(posedge clk);
    #1;
    chk("stays_idle", {31'h0, o_busy}, 32'h0);

    bp = 1'b0;
    rand_data(d);
    data = d;
    push_init();
    push_frame(d);
    en = 1'b1;
    wait_mid();
    chk("row_word_before_rst", {31'h0, o_valid}, 32'h1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("async_rst_word", {16'h0, o_word}, 32'h0);
    chk("async_rst_valid", {31'h0, o_valid}, 32'h0);
    chk("async_rst_load", {31'h0, o_load}, 32'h0);
    chk("async_rst_done", {31'h0, o_done}, 32'h0);
    chk("async_rst_busy", {31'h0, o_busy}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_busy", {31'h0, o_busy}, 32'h0);
    push_init();
    push_frame(d);
    f0 = frames_done;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (frames_done != f0) seen = 1'b1;
    end
    if (!seen) finish_now("frame_after_reset");
    en = 1'b0;
    wait_busy_low("final_idle");
    chk("final_busy", {31'h0, o_busy}, 32'h0);
    chk("final_queue_empty", exp_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/max7219_frame_sequencer.md
# max7219_frame_sequencer

Sequences MAX7219 traffic between the pattern generators and the word-level SPI shifter. After enable, it broadcasts the MAX7219 initialisation commands to every cascaded device. It then periodically snapshots the 8-stream framebuffer output and pushes it row by row: one 16-bit word per device, then a LOAD strobe per row. It owns all ordering, pacing and latch timing. The shifter only serialises words.

## Interface
- DISP_ROWS, 1, device rows in the cascade
- DISP_COLUMNS, 1, device columns in the cascade
- CLK_FREQ_HZ, 100_000_000, i_Clk frequency
- REFRESH_HZ, 10, frame rate; period P = CLK_FREQ_HZ/REFRESH_HZ cycles (integer divide, P >= 2)
- INTENSITY, 4'h8, value written to register 0xA
- Derived: N = DISP_ROWS*DISP_COLUMNS devices.

Ports:
- i_Clk  in  1  clock; all logic on posedge
- i_Rst  in  1  reset, asynchronous, active-high
- i_Enable  in  1  run request; level-sensitive
- i_DataStream  in  [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0]  packed {hdr, addr, data} words from the pattern generator
- o_Word  out  16  word to shifter
- o_Word_Valid  out  1  o_Word valid
- i_Word_Ready  in  1  shifter accepts o_Word this cycle
- i_Shifter_Idle  in  1  shifter has finished clocking out all accepted bits
- o_Load  out  1  one-cycle LOAD/CS latch strobe
- o_Frame_Done  out  1  one-cycle pulse per completed frame
- o_Busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, INIT_WORD, INIT_LOAD, WAIT, ROW_WORD, ROW_LOAD.
- IDLE: all outputs 0, counters 0. When i_Enable=1, go to INIT_WORD and reset the refresh timer.
- Init command list, in order:
  - 0xF=0x00 (test off)
  - 0xB=0x07 (scan limit)
  - 0x9=0x00 (no decode)
  - 0xA={4'h0,INTENSITY}
  - 0xC=0x01 (normal operation)
- Init word format: {4'h0, addr[3:0], data[7:0]}.
- INIT_WORD: present the current command N times, once per device, then go to INIT_LOAD.
  - INIT_LOAD: after the LOAD strobe, advance to the next command.
  - After the 5th command, go to ROW_WORD for the first frame. That frame starts immediately and is not tick-gated.
- Frame start: capture all of i_DataStream into a snapshot register in the cycle the frame begins.
  - A frame sends streams s = 0..7.
  - For each stream, ROW_WORD sends devices d = N-1 down to 0, where d = r*DISP_COLUMNS + c; word = snapshot[s][r][c].
  - ROW_LOAD follows each stream.
- After the 8th ROW_LOAD: pulse o_Frame_Done for one cycle and enter WAIT.
- WAIT: on a refresh tick, go to ROW_WORD with a new snapshot.
  - If i_Enable=0 at the WAIT check, go to IDLE instead.
  - i_Enable is ignored mid-frame or mid-init; the current frame always completes.
- Handshake:
  - A word transfers on a posedge with o_Word_Valid && i_Word_Ready.
  - o_Word is stable while valid and unaccepted.
  - The next word is presented in the cycle after acceptance, with no bubble.
- LOAD states:
  - o_Word_Valid=0.
  - Wait until i_Shifter_Idle=1, then assert o_Load for exactly one cycle.
  - Leave the state the cycle after o_Load.
- Refresh timer:
  - Free-running modulo P while not IDLE; tick when it wraps to 0.
  - A tick during a frame sets a single pending flag. Multiple ticks collapse into one.
  - WAIT consumes the pending flag immediately.
- Counters: device index width $clog2(N)+1; stream index 3 bits; command index 3 bits; timer width $clog2(P).

## Timing
- Reset (async assert, sync release): state IDLE; o_Word=0, o_Word_Valid=0, o_Load=0, o_Frame_Done=0, o_Busy=0; timer, pending flag and snapshot cleared.
- Reset mid-transfer aborts immediately with no trailing o_Load. The next enable re-runs init.
- i_Enable sampled high at edge k: at edge k+1 the state is INIT_WORD, o_Busy=1, o_Word_Valid=1, o_Word=16'h0F00.
- Zero-wait throughput with i_Word_Ready=1 and i_Shifter_Idle=1:
  - N word cycles plus 1 o_Load cycle per group.
  - Init takes 5(N+1) cycles; a frame takes 8(N+1) cycles.
- o_Frame_Done is asserted in the cycle after the 8th o_Load.
- P < 8(N+1) is legal: frames then run back-to-back with one WAIT cycle between them.

## Test plan
- Init, N=1, ready/idle tied high: enable pulse → words 0F00, 0B07, 0900, 0A08, 0C01, each followed by exactly one o_Load; then 8 row words and 8 o_Loads, then o_Frame_Done.
- DISP_ROWS=1, DISP_COLUMNS=2, stream s device c = 16'h0100*(s+1) + c → per stream, the word for c=1 precedes c=0; 16 words and 8 loads per frame, in stream order 0..7.
- Backpressure: i_Word_Ready random 30%; i_Shifter_Idle deasserted for 5 cycles after each group → o_Word held while unaccepted; o_Load only when i_Shifter_Idle=1; no word lost or duplicated.
- Refresh: CLK_FREQ_HZ=1000, REFRESH_HZ=10 (P=100), N=1 → o_Frame_Done every 100 cycles; a stream change mid-frame appears only in the next frame.
- Disable mid-frame: i_Enable falls during stream 3 → frame completes (8 loads), then IDLE with o_Busy=0; re-enable → init repeats.
- Async i_Rst during ROW_WORD → all outputs 0 in the same cycle, no o_Load, state IDLE.
